// File: rtl/demux_pkg.sv
// Shared types, default sizes and the lane-mapping helper for the serial-to-parallel
// demultiplexer (demux1_8_deser) and its lane index counter.
package demux_pkg;

  localparam int DEMUX_LANES = 8;
  localparam int DEMUX_SEL_W = 3;

  typedef enum logic [1:0] {
    COLLECT,
    FULL,
    PARITY
  } state_e;

  // Translate a counter index into the physical lane it fills.
  function automatic int map_lane(input int idx, input int lanes, input bit lsb_first);
    return lsb_first ? idx : (lanes - 1 - idx);
  endfunction

endpackage

// File: rtl/demux1_8_deser_lane_index_ctr.sv
// Lane index counter: increments per stored bit, wraps naturally at 2**SEL_W,
// and can be synchronously cleared (clear applies before the increment).
module lane_index_ctr
  import demux_pkg::*;
#(
  parameter int SEL_W = DEMUX_SEL_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [SEL_W-1:0] sel_o,
  output logic             wrap_o
);

  logic [SEL_W-1:0] sel_q, sel_d;

  always_comb begin
    sel_d = sel_q;
    if (clr_i) sel_d = '0;
    if (inc_i) sel_d = sel_d + SEL_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sel_q <= '0;
    else         sel_q <= sel_d;
  end

  assign sel_o  = sel_q;
  assign wrap_o = &sel_q;

endmodule

// File: rtl/demux1_8_deser.sv
// Serial-to-parallel demultiplexer: assembles LANES serial bits into a word on a valid/ready port.
// Define DEMUX1_8_PARITY_EN to expect an even-parity bit after each word and report parity_err.
module demux1_8_deser
  import demux_pkg::*;
#(
  parameter int LANES     = DEMUX_LANES,
  parameter int SEL_W     = DEMUX_SEL_W,
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  input  logic             frame_sync,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LANES-1:0] out_data,
  output logic [SEL_W-1:0] sel,
  output logic             overrun
`ifdef DEMUX1_8_PARITY_EN
  ,output logic            parity_err
`endif
);

  state_e           state_q, state_d;
  logic [LANES-1:0] shadow_q, shadow_d;
  logic [LANES-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;
`ifdef DEMUX1_8_PARITY_EN
  logic             parity_err_q, parity_err_d;
`endif

  logic             accept;
  logic             store_bit;
  logic             last_lane;
  logic [SEL_W-1:0] sel_cnt;
  logic [SEL_W-1:0] lane_idx;

  assign in_ready = (state_q == FULL) ? out_ready : 1'b1;
  assign accept   = in_valid & in_ready;

  // A bit accepted in PARITY is the parity bit itself unless a sync restarts the word with it.
  assign store_bit = accept & ((state_q != PARITY) | frame_sync);

  // frame_sync takes effect before the bit, so a same-cycle bit lands in lane map(0).
  assign lane_idx = SEL_W'(map_lane(frame_sync ? 0 : int'(sel_cnt), LANES, LSB_FIRST != 0));

  lane_index_ctr #(
    .SEL_W (SEL_W)
  ) u_ctr (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .inc_i  (store_bit),
    .clr_i  (frame_sync),
    .sel_o  (sel_cnt),
    .wrap_o (last_lane)
  );

  always_comb begin
    state_d     = state_q;
    shadow_d    = frame_sync ? '0 : shadow_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q | (in_valid & ~in_ready);
`ifdef DEMUX1_8_PARITY_EN
    parity_err_d = parity_err_q;
`endif
    if (store_bit) shadow_d[lane_idx] = in_bit;

    case (state_q)
      COLLECT: begin
        if (accept && last_lane && !frame_sync) begin
`ifdef DEMUX1_8_PARITY_EN
          state_d = PARITY;
`else
          out_data_d  = shadow_d;
          out_valid_d = 1'b1;
          shadow_d    = '0;
          state_d     = FULL;
`endif
        end
      end
      FULL: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = COLLECT;
        end
      end
`ifdef DEMUX1_8_PARITY_EN
      PARITY: begin
        if (frame_sync) begin
          state_d = COLLECT;
        end else if (accept) begin
          out_data_d   = shadow_q;
          parity_err_d = ^{shadow_q, in_bit};
          out_valid_d  = 1'b1;
          shadow_d     = '0;
          state_d      = FULL;
        end
      end
`endif
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      shadow_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef DEMUX1_8_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err_q <= 1'b0;
    else        parity_err_q <= parity_err_d;
  end

  assign parity_err = parity_err_q;
`endif

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign sel       = sel_cnt;

endmodule

// File: tb/tb_demux1_8_deser.sv
// Directed self-checking bench for demux1_8_deser: an LSB-first and an MSB-first instance share stimulus.
// Word-sending adds the even-parity bit when DEMUX1_8_PARITY_EN is defined.
module tb_demux1_8_deser;

`ifdef DEMUX1_8_PARITY_EN
  localparam int WordCyc = 9;
`else
  localparam int WordCyc = 8;
`endif

  logic       clk;
  logic       rst_n;
  logic       inValid;
  logic       inBit;
  logic       frameSync;
  logic       outReady;

  logic       lsbInReady, lsbOutValid, lsbOverrun;
  logic [7:0] lsbOutData;
  logic [2:0] lsbSel;
  logic       msbInReady, msbOutValid, msbOverrun;
  logic [7:0] msbOutData;
  logic [2:0] msbSel;
`ifdef DEMUX1_8_PARITY_EN
  logic       lsbParityErr, msbParityErr;
`endif

  int checks   = 0;
  int failures = 0;

  demux1_8_deser #(.LANES(8), .SEL_W(3), .LSB_FIRST(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (inValid),
    .in_bit     (inBit),
    .in_ready   (lsbInReady),
    .frame_sync (frameSync),
    .out_valid  (lsbOutValid),
    .out_ready  (outReady),
    .out_data   (lsbOutData),
    .sel        (lsbSel),
    .overrun    (lsbOverrun)
`ifdef DEMUX1_8_PARITY_EN
    ,.parity_err (lsbParityErr)
`endif
  );

  demux1_8_deser #(.LANES(8), .SEL_W(3), .LSB_FIRST(0)) dutMsb (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (inValid),
    .in_bit     (inBit),
    .in_ready   (msbInReady),
    .frame_sync (frameSync),
    .out_valid  (msbOutValid),
    .out_ready  (outReady),
    .out_data   (msbOutData),
    .sel        (msbSel),
    .overrun    (msbOverrun)
`ifdef DEMUX1_8_PARITY_EN
    ,.parity_err (msbParityErr)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    inValid   = 1'b0;
    inBit     = 1'b0;
    frameSync = 1'b0;
    outReady  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Sends w[0] first, then the even-parity bit when parity is built in.
  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      inValid = 1'b1;
      inBit   = w[i];
      tick();
    end
`ifdef DEMUX1_8_PARITY_EN
    inBit = ^w;
    tick();
`endif
    inValid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    inValid   = 1'b0;
    inBit     = 1'b0;
    frameSync = 1'b0;
    outReady  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (lsbSel !== 3'd0) begin failures++; $display("[TB] FAIL reset_sel: got %0d expected 0", lsbSel); end
    checks++; if (lsbOutData !== 8'h00) begin failures++; $display("[TB] FAIL reset_out_data: got %h expected 00", lsbOutData); end
    checks++; if (lsbOutValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b expected 0", lsbOutValid); end
    checks++; if (lsbOverrun !== 1'b0) begin failures++; $display("[TB] FAIL reset_overrun: got %b expected 0", lsbOverrun); end
    checks++; if (lsbInReady !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready: got %b expected 1", lsbInReady); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lsb_first();
    do_reset();
    send_word(8'h4D);
    checks++; if (lsbOutValid !== 1'b1) begin failures++; $display("[TB] FAIL lsb_valid_rise: got %b expected 1", lsbOutValid); end
    checks++; if (lsbOutData !== 8'h4D) begin failures++; $display("[TB] FAIL lsb_data: got %h expected 4d", lsbOutData); end
    checks++; if (lsbSel !== 3'd0) begin failures++; $display("[TB] FAIL lsb_sel_wrap: got %0d expected 0", lsbSel); end
    tick();
    checks++; if (lsbOutValid !== 1'b0) begin failures++; $display("[TB] FAIL lsb_valid_one_cycle: got %b expected 0", lsbOutValid); end
  endtask

  task automatic test_msb_first();
    do_reset();
    send_word(8'h4D);
    checks++; if (msbOutValid !== 1'b1) begin failures++; $display("[TB] FAIL msb_valid: got %b expected 1", msbOutValid); end
    checks++; if (msbOutData !== 8'hB2) begin failures++; $display("[TB] FAIL msb_data: got %h expected b2", msbOutData); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    int         pos;
    logic       expValid;
    do_reset();
    for (int k = 0; k < 2 * WordCyc; k++) begin
      w   = (k < WordCyc) ? 8'hFF : 8'h00;
      pos = k % WordCyc;
      inValid = 1'b1;
      inBit   = (pos < 8) ? w[pos] : ^w;
      #1;
      checks++; if (lsbInReady !== 1'b1) begin failures++; $display("[TB] FAIL b2b_in_ready cycle %0d: got %b expected 1", k, lsbInReady); end
      @(posedge clk);
      #1;
      expValid = (k == WordCyc - 1) || (k == 2 * WordCyc - 1);
      checks++; if (lsbOutValid !== expValid) begin failures++; $display("[TB] FAIL b2b_valid cycle %0d: got %b expected %b", k, lsbOutValid, expValid); end
      if (k == WordCyc - 1) begin
        checks++; if (lsbOutData !== 8'hFF) begin failures++; $display("[TB] FAIL b2b_word0: got %h expected ff", lsbOutData); end
      end
      if (k == 2 * WordCyc - 1) begin
        checks++; if (lsbOutData !== 8'h00) begin failures++; $display("[TB] FAIL b2b_word1: got %h expected 00", lsbOutData); end
      end
    end
    inValid = 1'b0;
    tick();
    checks++; if (lsbOverrun !== 1'b0) begin failures++; $display("[TB] FAIL b2b_no_overrun: got %b expected 0", lsbOverrun); end
  endtask

  task automatic test_overrun();
    do_reset();
    outReady = 1'b0;
    send_word(8'h3C);
    for (int k = 0; k < 5; k++) begin
      inValid = 1'b1;
      inBit   = k[0];
      #1;
      checks++; if (lsbInReady !== 1'b0) begin failures++; $display("[TB] FAIL stall_in_ready cycle %0d: got %b expected 0", k, lsbInReady); end
      @(posedge clk);
      #1;
      checks++; if (lsbOutValid !== 1'b1) begin failures++; $display("[TB] FAIL stall_valid cycle %0d: got %b expected 1", k, lsbOutValid); end
      checks++; if (lsbOutData !== 8'h3C) begin failures++; $display("[TB] FAIL stall_data cycle %0d: got %h expected 3c", k, lsbOutData); end
      checks++; if (lsbOverrun !== 1'b1) begin failures++; $display("[TB] FAIL stall_overrun cycle %0d: got %b expected 1", k, lsbOverrun); end
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    tick();
    checks++; if (lsbOutValid !== 1'b0) begin failures++; $display("[TB] FAIL stall_drain: got %b expected 0", lsbOutValid); end
    send_word(8'h96);
    checks++; if (lsbOutData !== 8'h96) begin failures++; $display("[TB] FAIL after_stall_data: got %h expected 96", lsbOutData); end
    checks++; if (lsbOverrun !== 1'b1) begin failures++; $display("[TB] FAIL overrun_sticky: got %b expected 1", lsbOverrun); end
    tick();
  endtask

  task automatic test_reset_midword();
    logic [4:0] partial;
    partial = 5'b10101;
    for (int i = 0; i < 5; i++) begin
      inValid = 1'b1;
      inBit   = partial[i];
      tick();
    end
    inValid = 1'b0;
    checks++; if (lsbSel !== 3'd5) begin failures++; $display("[TB] FAIL midword_sel: got %0d expected 5", lsbSel); end
    rst_n = 1'b0;
    #1;
    checks++; if (lsbSel !== 3'd0) begin failures++; $display("[TB] FAIL async_sel: got %0d expected 0", lsbSel); end
    checks++; if (lsbOutData !== 8'h00) begin failures++; $display("[TB] FAIL async_out_data: got %h expected 00", lsbOutData); end
    checks++; if (lsbOverrun !== 1'b0) begin failures++; $display("[TB] FAIL async_overrun: got %b expected 0", lsbOverrun); end
    checks++; if (lsbOutValid !== 1'b0) begin failures++; $display("[TB] FAIL async_out_valid: got %b expected 0", lsbOutValid); end
    checks++; if (lsbInReady !== 1'b1) begin failures++; $display("[TB] FAIL async_in_ready: got %b expected 1", lsbInReady); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_frame_sync();
    logic [7:0] w;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      inValid = 1'b1;
      inBit   = 1'b1;
      tick();
    end
    inValid   = 1'b0;
    frameSync = 1'b1;
    tick();
    frameSync = 1'b0;
    checks++; if (lsbSel !== 3'd0) begin failures++; $display("[TB] FAIL sync_sel_clear: got %0d expected 0", lsbSel); end
    send_word(8'hA5);
    checks++; if (lsbOutData !== 8'hA5) begin failures++; $display("[TB] FAIL sync_data: got %h expected a5", lsbOutData); end
    checks++; if (lsbSel !== 3'd0) begin failures++; $display("[TB] FAIL sync_sel_after: got %0d expected 0", lsbSel); end
    tick();
    // Sync coinciding with the first bit of the next word.
    w = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      inValid = 1'b1;
      inBit   = 1'b1;
      tick();
    end
    inBit     = w[0];
    frameSync = 1'b1;
    tick();
    frameSync = 1'b0;
    checks++; if (lsbSel !== 3'd1) begin failures++; $display("[TB] FAIL sync_with_bit_sel: got %0d expected 1", lsbSel); end
    for (int i = 1; i < 8; i++) begin
      inBit = w[i];
      tick();
    end
`ifdef DEMUX1_8_PARITY_EN
    inBit = ^w;
    tick();
`endif
    inValid = 1'b0;
    checks++; if (lsbOutData !== 8'h5A) begin failures++; $display("[TB] FAIL sync_with_bit_data: got %h expected 5a", lsbOutData); end
    checks++; if (lsbOutValid !== 1'b1) begin failures++; $display("[TB] FAIL sync_with_bit_valid: got %b expected 1", lsbOutValid); end
    tick();
  endtask

`ifdef DEMUX1_8_PARITY_EN
  task automatic test_parity();
    logic [7:0] w;
    do_reset();
    w = 8'h03;
    for (int i = 0; i < 8; i++) begin
      inValid = 1'b1;
      inBit   = w[i];
      tick();
    end
    checks++; if (lsbOutValid !== 1'b0) begin failures++; $display("[TB] FAIL parity_wait_valid: got %b expected 0", lsbOutValid); end
    inBit = 1'b1;
    tick();
    inValid = 1'b0;
    checks++; if (lsbOutValid !== 1'b1) begin failures++; $display("[TB] FAIL parity_valid: got %b expected 1", lsbOutValid); end
    checks++; if (lsbOutData !== 8'h03) begin failures++; $display("[TB] FAIL parity_data: got %h expected 03", lsbOutData); end
    checks++; if (lsbParityErr !== 1'b1) begin failures++; $display("[TB] FAIL parity_err_bad: got %b expected 1", lsbParityErr); end
    tick();
    send_word(8'h03);
    checks++; if (lsbParityErr !== 1'b0) begin failures++; $display("[TB] FAIL parity_err_good: got %b expected 0", lsbParityErr); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_back_to_back();
    test_overrun();
    test_reset_midword();
    test_frame_sync();
`ifdef DEMUX1_8_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux1_8_deser.md
Name: demux1_8_deser

Overview:
- Serial-to-parallel demultiplexer; the inverse of the team's 8:1 bit selector.
- Routes a stream of single bits onto eight output lanes, selecting the lane with an internal 3-bit index counter.
- Presents the completed byte on a valid/ready output port.
- Sits on the receive side of serial links, feeding byte-wide logic downstream.

Parameters:
- LANES, 8, number of output lanes (power of two, >=2).
- SEL_W, 3, index counter width, equal to log2(LANES).
- LSB_FIRST, 1: 1 = first accepted bit lands in lane 0; 0 = first bit lands in lane LANES-1.

Ports:
- clk  input  1  single rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_bit is valid this cycle.
- in_bit  input  1  serial data bit.
- in_ready  output  1  block can accept a bit this cycle.
- frame_sync  input  1  aligns the index to lane 0 and discards the partial word.
- out_valid  output  1  out_data holds a complete word.
- out_ready  input  1  downstream accepts the word.
- out_data  output  LANES  assembled word; bit k = lane k.
- sel  output  SEL_W  current lane index (debug/visibility).
- overrun  output  1  sticky; set when a bit is presented while in_ready=0.

Behaviour:
- Interface: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset values: sel=0, out_data=0, out_valid=0, overrun=0, FSM=COLLECT. in_ready is 1 out of reset.
- Handshakes: an input bit is accepted when in_valid && in_ready. An output word is taken when out_valid && out_ready.
- FSM states: COLLECT and FULL (plus PARITY under the optional feature).
- COLLECT:
  - On each accepted bit, the shadow register lane[map(sel)] <= in_bit and sel <= sel+1.
  - map(sel) = sel if LSB_FIRST=1, else LANES-1-sel.
  - When the accepted bit has sel=LANES-1: sel wraps to 0, out_data <= shadow including this bit, out_valid <= 1, FSM goes to FULL.
  - Latency: out_valid rises on the cycle after the last bit is accepted.
- FULL:
  - in_ready = out_ready. This gives full throughput: when the word drains, a new bit can be accepted in the same cycle.
  - If out_ready=1 and no bit is accepted: out_valid <= 0, FSM goes to COLLECT.
  - If out_ready=1 and a bit is accepted: the bit goes to lane map(0), sel <= 1, out_valid <= 0, FSM goes to COLLECT.
  - If out_ready=0: out_data and out_valid hold stable. in_valid=1 sets overrun, and the bit is dropped.
- in_ready = 1 in COLLECT.
- frame_sync:
  - Effective in any state. Sets sel <= 0 and clears the shadow register.
  - A bit accepted in the same cycle is stored in lane map(0) and sel <= 1 (sync first, then the bit).
  - A pending word in FULL is not discarded; out_valid stays until it is drained.
- overrun is cleared only by reset.
- Asserting rst_n low mid-word clears everything asynchronously. The partial word is lost.

Optional Feature:
- Macro: DEMUX1_8_PARITY_EN.
- Enabled:
  - Each word is followed by one even-parity bit. After lane LANES-1 is filled, the FSM enters PARITY and waits for one accepted bit.
  - Then out_valid <= 1 with a new output parity_err = (XOR of data ^ parity bit).
  - frame_sync while in PARITY returns the FSM to COLLECT and discards the word.
- Disabled: no PARITY state; the parity_err port is absent.

Decomposition:
- Package demux_pkg holds:
  - state enum {COLLECT, FULL, PARITY};
  - the LANES/SEL_W defaults;
  - the lane-mapping function.
- One sub-module, lane_index_ctr: SEL_W-bit counter with inc, sync-clear, wrap flag.
- The FSM and datapath stay in the top level.

Test Plan:
- Reset then bits 1,0,1,1,0,0,1,0 with LSB_FIRST=1 and out_ready=1 -> out_data=8'h4D. out_valid is high for exactly 1 cycle, one cycle after the 8th bit.
- The same stream with LSB_FIRST=0 -> out_data=8'hB2.
- Back-to-back words 8'hFF then 8'h00 with in_valid held high and out_ready=1 -> no bubble (in_ready stays 1), two words out, 8 cycles apart.
- out_ready=0 for 5 cycles after a word completes, with in_valid=1 -> in_ready=0, out_data stable, overrun=1. After out_ready=1, the next word assembles correctly.
- frame_sync pulsed after 3 bits, then 8 bits of 8'hA5 -> out_data=8'hA5, and sel reads 0 after the word.
- rst_n asserted low mid-word at sel=5 -> all outputs immediately return to reset values. With DEMUX1_8_PARITY_EN, sending 8'h03 plus parity bit 1 -> parity_err=1.
